wb_openram_arbiter: RTL
=======================

# wb_openram_arbiter

Two-master Wishbone arbiter and sequencer in front of one OpenRAM RW port (port 0). Master A (management SoC bus) and master B (user-project master) each see a 32-bit Wishbone B4 classic slave; the block grants the RAM to one master at a time with round-robin fairness. It generates the macro's active-low chip select, write enable and byte mask from registered copies of the granted request.

## Interface
- BASE_ADDR, 32'h3000_0000: base of the RAM window; address matches when `(adr & ~((1<<ADDR_WIDTH+2)-1)) == BASE_ADDR`.
- ADDR_WIDTH, 8: RAM word-address width; byte address bits [ADDR_WIDTH+1:2] select the word.

Ports:
- wb_clk_i  in  1  clock; also drives the macro clock. Single clock domain.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_a_cyc_i, wbs_a_stb_i, wbs_a_we_i  in  1 each  master A cycle, strobe, write enable.
- wbs_a_sel_i  in  4  master A byte selects.
- wbs_a_adr_i, wbs_a_dat_i  in  32 each  master A address and write data.
- wbs_a_ack_o  out  1  master A acknowledge.
- wbs_a_dat_o  out  32  master A read data.
- wbs_b_*  same set and widths for master B.
- ram_clk0  out  1  equals wb_clk_i.
- ram_csb0  out  1  active-low chip select.
- ram_web0  out  1  active-low write enable.
- ram_wmask0  out  4  byte write mask.
- ram_addr0  out  ADDR_WIDTH  word address.
- ram_dout0  out  32  write data to the macro.
- ram_din0  in  32  read data from the macro.

## Operation
- A request is valid when `req_x = cyc & stb & address match`. Requests outside the window are ignored and never acknowledged.
- Round-robin arbitration uses a `last` register (reset value: B).
  - Single request: that master is granted.
  - Both requesting: the master other than `last` is granted.
  - `last` updates when a grant is taken.
- FSM has states IDLE, ACCESS, CAPTURE, ACK.
  - **IDLE.** If any request is valid, register `grant`, `we`, `sel`, word address and write data, then go to ACCESS.
  - **ACCESS.** csb0=0; web0=~we_r; wmask0 = we_r ? sel_r : 4'h0; address and dout come from the registers. Writes go to ACK; reads go to CAPTURE.
  - **CAPTURE.** csb0=1. Latch ram_din0 into `rdata_r`, then go to ACK.
  - **ACK.** Raise ack of the granted master for exactly one cycle, gated by that master's live cyc & stb. Return to IDLE.
- Read data: wbs_x_dat_o = rdata_r for both masters. The value is only meaningful when ack is asserted.
- Abort: if the granted master drops cyc during ACCESS or CAPTURE, the sequence still completes and the RAM write still occurs. No ack is issued, and no retry happens.
- The block issues no back-to-back grants. IDLE always lasts at least one cycle between transactions.

## Timing
- Reset values: all acks 0, ram_csb0 1, ram_web0 1, ram_wmask0 0, ram_addr0 0, ram_dout0 0, dat_o 0, FSM in IDLE.
- Reset asserted in any state returns to IDLE on the next edge. A transaction in flight is dropped without ack.
- Request sampled in IDLE at edge N:
  - write: csb0 low during cycle N+1, ack during cycle N+2;
  - read: csb0 low during N+1, data latched at the end of N+2, ack during N+3.
- The master must hold request signals until ack; registered copies are what the macro sees.
- A non-granted master is stalled with ack held at 0. It is served in the next IDLE if still requesting.
- csb0 is low for exactly one cycle per transaction.

## Structure
- Package `wb_openram_pkg` holds:
  - the FSM state enum (IDLE, ACCESS, CAPTURE, ACK);
  - master index constants (MST_A=0, MST_B=1);
  - the address-match function parameterised by BASE_ADDR and ADDR_WIDTH.
- Sub-module `openram_rr_arb2` contains the 2-way round-robin grant with its `last` register. It has inputs req[1:0] and take; it outputs grant_idx and any_req.
- The top level holds the FSM, request registers, the read-data register and ack gating.

## Test plan
- **Single write/read.** A writes 32'hDEADBEEF with sel 4'hF to BASE_ADDR+0x10. Required: ack after 2 cycles, and ram_addr0=4 with csb0 low for exactly one cycle. A then reads the same address: ack after 3 cycles with dat_o=32'hDEADBEEF.
- **Byte mask.** B writes 32'h11223344 with sel 4'b0101 over 32'hFFFFFFFF at the same word. Required: ram_wmask0=4'b0101 during ACCESS, and a read-back returns 32'hFF22FF44.
- **Contention.** A and B request on the same cycle out of reset. Required: A is served first, then B. A second simultaneous pair is served B-first, and grant order alternates for 8 transactions.
- **Out of window.** A accesses 32'h3000_1000 (ADDR_WIDTH=8). Required: no csb0 pulse and no ack for 10 cycles, while B's concurrent request proceeds normally.
- **Abort.** A drops cyc during ACCESS of a write. Required: the RAM word is updated, wbs_a_ack_o stays 0, and the FSM is back in IDLE 2 cycles later.
- **Reset mid-read.** wb_rst_i is asserted in CAPTURE. Required: next cycle shows FSM IDLE, csb0=1, and no ack. A fresh read then completes with correct data.

Source files
------------

// File: rtl/wb_openram_pkg.sv
// Shared types and helpers for the two-master Wishbone front end of an OpenRAM RW port.
package wb_openram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  localparam logic MST_A = 1'b0;
  localparam logic MST_B = 1'b1;

  // True when adr falls inside the (1 << (aw+2))-byte window starting at base.
  function automatic logic addr_match(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input int unsigned aw);
    logic [31:0] mask;
    mask = ~((32'd1 << (aw + 32'd2)) - 32'd1);
    return (adr & mask) == base;
  endfunction

endpackage

// File: rtl/openram_rr_arb2.sv
// Two-way round-robin grant; last_reg remembers which master was served most recently.
module openram_rr_arb2
  import wb_openram_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       grant_idx,
  output logic       any_req
);

  logic last_reg;

  always_comb begin
    any_req   = |req;
    grant_idx = MST_A;
    case (req)
      2'b01:   grant_idx = MST_A;
      2'b10:   grant_idx = MST_B;
      2'b11:   grant_idx = ~last_reg;
      default: grant_idx = MST_A;
    endcase
  end

  // Starting from B means A wins the very first tie after reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      last_reg <= MST_B;
    end else if (take) begin
      last_reg <= grant_idx;
    end
  end

endmodule

// File: rtl/wb_openram_arbiter.sv
// Arbitrates two Wishbone classic slaves onto OpenRAM port 0 and sequences
// each access as IDLE -> ACCESS -> (CAPTURE) -> ACK.
module wb_openram_arbiter
  import wb_openram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          ADDR_WIDTH = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_a_cyc_i,
  input  logic                  wbs_a_stb_i,
  input  logic                  wbs_a_we_i,
  input  logic [3:0]            wbs_a_sel_i,
  input  logic [31:0]           wbs_a_adr_i,
  input  logic [31:0]           wbs_a_dat_i,
  output logic                  wbs_a_ack_o,
  output logic [31:0]           wbs_a_dat_o,
  input  logic                  wbs_b_cyc_i,
  input  logic                  wbs_b_stb_i,
  input  logic                  wbs_b_we_i,
  input  logic [3:0]            wbs_b_sel_i,
  input  logic [31:0]           wbs_b_adr_i,
  input  logic [31:0]           wbs_b_dat_i,
  output logic                  wbs_b_ack_o,
  output logic [31:0]           wbs_b_dat_o,
  output logic                  ram_clk0,
  output logic                  ram_csb0,
  output logic                  ram_web0,
  output logic [3:0]            ram_wmask0,
  output logic [ADDR_WIDTH-1:0] ram_addr0,
  output logic [31:0]           ram_dout0,
  input  logic [31:0]           ram_din0
);

  logic [1:0]  mst_cyc;
  logic [1:0]  mst_stb;
  logic [1:0]  mst_we;
  logic [3:0]  mst_sel [2];
  logic [31:0] mst_adr [2];
  logic [31:0] mst_dat [2];
  logic [1:0]  req;
  logic [1:0]  ack;

  logic        grant_idx;
  logic        any_req;
  logic        take;

  state_t                state_reg;
  logic                  grant_reg;
  logic                  we_reg;
  logic [3:0]            sel_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [31:0]           wdata_reg;
  logic [31:0]           rdata_reg;
  logic                  aborted_reg;
  logic                  csb_reg;
  logic                  web_reg;
  logic [3:0]            wmask_reg;

  assign mst_cyc    = {wbs_b_cyc_i, wbs_a_cyc_i};
  assign mst_stb    = {wbs_b_stb_i, wbs_a_stb_i};
  assign mst_we     = {wbs_b_we_i,  wbs_a_we_i};
  assign mst_sel[0] = wbs_a_sel_i;
  assign mst_sel[1] = wbs_b_sel_i;
  assign mst_adr[0] = wbs_a_adr_i;
  assign mst_adr[1] = wbs_b_adr_i;
  assign mst_dat[0] = wbs_a_dat_i;
  assign mst_dat[1] = wbs_b_dat_i;

  // Ack only reaches the granted master if it is still on the bus and never let go mid-sequence.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mst
    assign req[gi] = mst_cyc[gi] & mst_stb[gi] &
                     addr_match(mst_adr[gi], BASE_ADDR, ADDR_WIDTH);
    assign ack[gi] = (state_reg == ACK) && (grant_reg == 1'(gi)) && !aborted_reg &&
                     mst_cyc[gi] && mst_stb[gi];
  end

  assign take = (state_reg == IDLE) && any_req;

  openram_rr_arb2 u_arb (
    .clk       (wb_clk_i),
    .srst      (wb_rst_i),
    .req       (req),
    .take      (take),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg   <= IDLE;
      grant_reg   <= MST_A;
      we_reg      <= 1'b0;
      sel_reg     <= 4'h0;
      addr_reg    <= '0;
      wdata_reg   <= 32'h0;
      rdata_reg   <= 32'h0;
      aborted_reg <= 1'b0;
      csb_reg     <= 1'b1;
      web_reg     <= 1'b1;
      wmask_reg   <= 4'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            grant_reg   <= grant_idx;
            we_reg      <= mst_we[grant_idx];
            sel_reg     <= mst_sel[grant_idx];
            addr_reg    <= mst_adr[grant_idx][ADDR_WIDTH+1:2];
            wdata_reg   <= mst_dat[grant_idx];
            aborted_reg <= 1'b0;
            csb_reg     <= 1'b0;
            web_reg     <= ~mst_we[grant_idx];
            wmask_reg   <= mst_we[grant_idx] ? mst_sel[grant_idx] : 4'h0;
            state_reg   <= ACCESS;
          end
        end
        ACCESS: begin
          csb_reg   <= 1'b1;
          web_reg   <= 1'b1;
          wmask_reg <= 4'h0;
          if (!mst_cyc[grant_reg]) aborted_reg <= 1'b1;
          state_reg <= we_reg ? ACK : CAPTURE;
        end
        CAPTURE: begin
          rdata_reg <= ram_din0;
          if (!mst_cyc[grant_reg]) aborted_reg <= 1'b1;
          state_reg <= ACK;
        end
        ACK: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ram_clk0    = wb_clk_i;
  assign ram_csb0    = csb_reg;
  assign ram_web0    = web_reg;
  assign ram_wmask0  = wmask_reg;
  assign ram_addr0   = addr_reg;
  assign ram_dout0   = wdata_reg;
  assign wbs_a_ack_o = ack[0];
  assign wbs_b_ack_o = ack[1];
  assign wbs_a_dat_o = rdata_reg;
  assign wbs_b_dat_o = rdata_reg;

  // ADDR_WIDTH is sized by the instantiating macro; warn loudly if it can't fit a 32-bit address.
  initial_width_guard: assert property (@(posedge wb_clk_i) (ADDR_WIDTH + 2) <= 32);

endmodule
